// File: rtl/msp430_ctrl_fsm_pkg.sv
// Shared encodings for the MSP430 control sequencer: FSM states, MAB selects,
// instruction formats and the format I / format II opcode constants.
package msp430_ctrl_fsm_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_SRC_EXT = 4'd2;
    localparam logic [3:0] ST_SRC_RD  = 4'd3;
    localparam logic [3:0] ST_DST_EXT = 4'd4;
    localparam logic [3:0] ST_DST_RD  = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_DST_WR  = 4'd7;
    localparam logic [3:0] ST_JUMP    = 4'd8;

    localparam logic [1:0] MAB_PC  = 2'd0;
    localparam logic [1:0] MAB_SRC = 2'd1;
    localparam logic [1:0] MAB_DST = 2'd2;

    typedef logic [1:0] fmt_t;
    localparam fmt_t FMT_NONE = 2'd0;
    localparam fmt_t FMT_I    = 2'd1;
    localparam fmt_t FMT_II   = 2'd2;
    localparam fmt_t FMT_J    = 2'd3;

    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_BIT  = 4'hB;
    localparam logic [3:0] OP_BIC  = 4'hC;
    localparam logic [3:0] OP_BIS  = 4'hD;

    localparam logic [2:0] FS_RRC  = 3'd0;
    localparam logic [2:0] FS_SWPB = 3'd1;
    localparam logic [2:0] FS_RRA  = 3'd2;
    localparam logic [2:0] FS_SXT  = 3'd3;
    localparam logic [2:0] FS_PUSH = 3'd4;
    localparam logic [2:0] FS_CALL = 3'd5;
    localparam logic [2:0] FS_RETI = 3'd6;

endpackage

// File: rtl/msp430_mode_dec.sv
// Combinational addressing-mode decoder: works out which memory phases the
// instruction in ir needs and which writes it performs.
module msp430_mode_dec
    import msp430_ctrl_fsm_pkg::*;
#(
    parameter bit CG_ENABLE = 1'b1
) (
    input  logic [15:0] i_ir,
    output fmt_t        o_fmt,
    output logic        o_need_src_ext,
    output logic        o_need_src_rd,
    output logic        o_need_dst_ext,
    output logic        o_need_dst_rd,
    output logic        o_need_dst_wr,
    output logic        o_ainc,
    output logic [1:0]  o_ainc_amt,
    output logic        o_illegal_op,
    output logic        o_msr,
    output logic        o_rw
);

    fmt_t       w_fmt;
    logic [3:0] w_op;
    logic [2:0] w_op2;
    logic [3:0] w_reg;
    logic [1:0] w_as;
    logic       w_ad;
    logic       w_bw;
    logic       w_fmt1;
    logic       w_has_src;
    logic       w_cg;
    logic       w_single_ok;

    always_comb begin
        w_fmt = FMT_NONE;
        if (i_ir[15:13] == 3'b001)
            w_fmt = FMT_J;
        else if (i_ir[15:12] == 4'b0001)
            w_fmt = FMT_II;
        else if (i_ir[15:12] >= 4'h4)
            w_fmt = FMT_I;
    end

    assign w_fmt1    = (w_fmt == FMT_I);
    assign w_has_src = w_fmt1 || (w_fmt == FMT_II);
    assign w_op      = i_ir[15:12];
    assign w_op2     = i_ir[9:7];
    assign w_reg     = w_fmt1 ? i_ir[11:8] : i_ir[3:0];
    assign w_as      = i_ir[5:4];
    assign w_ad      = i_ir[7];
    assign w_bw      = i_ir[6];

    // R3 in any mode and R2 in modes 10/11 synthesise constants, never touching memory
    assign w_cg = CG_ENABLE && ((w_reg == 4'd3) || ((w_reg == 4'd2) && w_as[1]));

    // Only the four shift/extend ops are implemented in format II
    assign w_single_ok = (w_fmt == FMT_II) && (w_op2 <= FS_SXT);

    assign o_need_src_ext = w_has_src && !w_cg &&
                            ((w_as == 2'b01) || ((w_as == 2'b11) && (w_reg == 4'd0)));
    assign o_need_src_rd  = w_has_src && !w_cg &&
                            ((w_as == 2'b01) || (w_as == 2'b10) ||
                             ((w_as == 2'b11) && (w_reg != 4'd0)));
    assign o_need_dst_ext = w_fmt1 && w_ad;
    assign o_need_dst_rd  = o_need_dst_ext && (w_op != OP_MOV);
    assign o_need_dst_wr  = (w_fmt1 && w_ad && (w_op != OP_CMP) && (w_op != OP_BIT)) ||
                            (w_single_ok && o_need_src_rd);

    assign o_ainc     = w_has_src && !w_cg && (w_as == 2'b11) && (w_reg != 4'd0);
    assign o_ainc_amt = (w_bw && (w_reg > 4'd1)) ? 2'd1 : 2'd2;

    assign o_fmt        = w_fmt;
    assign o_illegal_op = (w_fmt == FMT_NONE) || ((w_fmt == FMT_II) && !w_single_ok);
    assign o_rw         = (w_fmt1 && (w_op != OP_CMP) && (w_op != OP_BIT)) || w_single_ok;
    assign o_msr        = (w_fmt1 && (w_op != OP_MOV) && (w_op != OP_BIC) && (w_op != OP_BIS)) ||
                          (w_single_ok && (w_op2 != FS_SWPB));

endmodule

// File: rtl/msp430_ctrl_fsm.sv
// MSP430 control sequencer: walks one instruction through fetch, extension
// words, operand reads, execute, writeback or jump.
module msp430_ctrl_fsm
    import msp430_ctrl_fsm_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = ST_FETCH,
    parameter bit         CG_ENABLE   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_ir,
    input  logic        i_mem_ready,
    input  logic        i_jump_taken,
    output logic [1:0]  o_mab_sel,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic        o_ir_load,
    output logic        o_src_ext_load,
    output logic        o_dst_ext_load,
    output logic        o_src_op_load,
    output logic        o_dst_op_load,
    output logic        o_reg_we,
    output logic        o_sr_we,
    output logic        o_ainc_we,
    output logic [1:0]  o_ainc_amt,
    output logic        o_instr_done,
    output logic        o_illegal,
    output logic [3:0]  o_state
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    fmt_t       w_fmt;
    logic       w_need_src_ext, w_need_src_rd, w_need_dst_ext, w_need_dst_rd, w_need_dst_wr;
    logic       w_ainc, w_illegal_op, w_msr, w_rw;
    logic [1:0] w_ainc_amt;
    logic [3:0] w_after_src_rd, w_after_src_ext, w_after_decode, w_after_dst_ext;

    msp430_mode_dec #(.CG_ENABLE(CG_ENABLE)) u_mode_dec (
        .i_ir           (i_ir),
        .o_fmt          (w_fmt),
        .o_need_src_ext (w_need_src_ext),
        .o_need_src_rd  (w_need_src_rd),
        .o_need_dst_ext (w_need_dst_ext),
        .o_need_dst_rd  (w_need_dst_rd),
        .o_need_dst_wr  (w_need_dst_wr),
        .o_ainc         (w_ainc),
        .o_ainc_amt     (w_ainc_amt),
        .o_illegal_op   (w_illegal_op),
        .o_msr          (w_msr),
        .o_rw           (w_rw)
    );

    // Each phase hands over to the first later phase the instruction still needs
    assign w_after_dst_ext = w_need_dst_rd  ? ST_DST_RD  : ST_EXEC;
    assign w_after_src_rd  = w_need_dst_ext ? ST_DST_EXT : ST_EXEC;
    assign w_after_src_ext = w_need_src_rd  ? ST_SRC_RD  : w_after_src_rd;
    assign w_after_decode  = w_need_src_ext ? ST_SRC_EXT : w_after_src_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= RESET_STATE;
        else
            r_state <= w_next;
    end

    // Outputs are forced low while reset is held so an in-flight write is dropped
    always_comb begin
        w_next         = r_state;
        o_mab_sel      = MAB_PC;
        o_mem_rd       = 1'b0;
        o_mem_wr       = 1'b0;
        o_pc_inc       = 1'b0;
        o_pc_load      = 1'b0;
        o_ir_load      = 1'b0;
        o_src_ext_load = 1'b0;
        o_dst_ext_load = 1'b0;
        o_src_op_load  = 1'b0;
        o_dst_op_load  = 1'b0;
        o_reg_we       = 1'b0;
        o_sr_we        = 1'b0;
        o_ainc_we      = 1'b0;
        o_ainc_amt     = 2'd0;
        o_instr_done   = 1'b0;
        o_illegal      = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_FETCH: begin
                    o_mem_rd = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_load = 1'b1;
                        o_pc_inc  = 1'b1;
                        w_next    = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal_op) begin
                        o_illegal = 1'b1;
                        w_next    = ST_FETCH;
                    end else if (w_fmt == FMT_J) begin
                        w_next = ST_JUMP;
                    end else begin
                        w_next = w_after_decode;
                    end
                end
                ST_SRC_EXT: begin
                    o_mem_rd = 1'b1;
                    if (i_mem_ready) begin
                        o_src_ext_load = 1'b1;
                        o_pc_inc       = 1'b1;
                        w_next         = w_after_src_ext;
                    end
                end
                ST_SRC_RD: begin
                    o_mab_sel = MAB_SRC;
                    o_mem_rd  = 1'b1;
                    if (i_mem_ready) begin
                        o_src_op_load = 1'b1;
                        w_next        = w_after_src_rd;
                    end
                end
                ST_DST_EXT: begin
                    o_mem_rd = 1'b1;
                    if (i_mem_ready) begin
                        o_dst_ext_load = 1'b1;
                        o_pc_inc       = 1'b1;
                        w_next         = w_after_dst_ext;
                    end
                end
                ST_DST_RD: begin
                    o_mab_sel = MAB_DST;
                    o_mem_rd  = 1'b1;
                    if (i_mem_ready) begin
                        o_dst_op_load = 1'b1;
                        w_next        = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_sr_we    = w_msr;
                    o_reg_we   = w_rw && !w_need_dst_wr;
                    o_ainc_we  = w_ainc;
                    o_ainc_amt = w_ainc ? w_ainc_amt : 2'd0;
                    if (w_need_dst_wr) begin
                        w_next = ST_DST_WR;
                    end else begin
                        o_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
                ST_DST_WR: begin
                    o_mab_sel = MAB_DST;
                    o_mem_wr  = 1'b1;
                    if (i_mem_ready) begin
                        o_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
                ST_JUMP: begin
                    o_pc_load    = i_jump_taken;
                    o_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end
                default: w_next = ST_FETCH;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_msp430_ctrl_fsm.sv
// Per-cycle vector bench for msp430_ctrl_fsm: each vector gives the inputs and
// the expected state, MAB select and strobe set for that cycle.
module tb_msp430_ctrl_fsm;
    import msp430_ctrl_fsm_pkg::*;

    localparam logic [15:0] F_RD   = 16'h0001;
    localparam logic [15:0] F_WR   = 16'h0002;
    localparam logic [15:0] F_PCI  = 16'h0004;
    localparam logic [15:0] F_PCL  = 16'h0008;
    localparam logic [15:0] F_IRL  = 16'h0010;
    localparam logic [15:0] F_SXL  = 16'h0020;
    localparam logic [15:0] F_DXL  = 16'h0040;
    localparam logic [15:0] F_SOL  = 16'h0080;
    localparam logic [15:0] F_DOL  = 16'h0100;
    localparam logic [15:0] F_RWE  = 16'h0200;
    localparam logic [15:0] F_SWE  = 16'h0400;
    localparam logic [15:0] F_AWE  = 16'h0800;
    localparam logic [15:0] F_AM1  = 16'h1000;
    localparam logic [15:0] F_AM2  = 16'h2000;
    localparam logic [15:0] F_DONE = 16'h4000;
    localparam logic [15:0] F_ILL  = 16'h8000;
    localparam logic [15:0] F_FET  = F_RD | F_PCI | F_IRL;

    typedef struct packed {
        logic        rst;
        logic [15:0] ir;
        logic        rdy;
        logic        jt;
        logic [3:0]  st;
        logic [1:0]  mab;
        logic [15:0] fl;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        rdy;
    logic        jt;
    logic [1:0]  mab_sel;
    logic        mem_rd, mem_wr, pc_inc, pc_load, ir_load;
    logic        src_ext_load, dst_ext_load, src_op_load, dst_op_load;
    logic        reg_we, sr_we, ainc_we, instr_done, illegal;
    logic [1:0]  ainc_amt;
    logic [3:0]  state;
    logic [15:0] got_fl;

    vec_t        vecs[$];
    logic [21:0] exp_q[$];
    int          checks;
    int          failures;

    msp430_ctrl_fsm dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ir           (ir),
        .i_mem_ready    (rdy),
        .i_jump_taken   (jt),
        .o_mab_sel      (mab_sel),
        .o_mem_rd       (mem_rd),
        .o_mem_wr       (mem_wr),
        .o_pc_inc       (pc_inc),
        .o_pc_load      (pc_load),
        .o_ir_load      (ir_load),
        .o_src_ext_load (src_ext_load),
        .o_dst_ext_load (dst_ext_load),
        .o_src_op_load  (src_op_load),
        .o_dst_op_load  (dst_op_load),
        .o_reg_we       (reg_we),
        .o_sr_we        (sr_we),
        .o_ainc_we      (ainc_we),
        .o_ainc_amt     (ainc_amt),
        .o_instr_done   (instr_done),
        .o_illegal      (illegal),
        .o_state        (state)
    );

    assign got_fl = {illegal, instr_done, ainc_amt, ainc_we, sr_we, reg_we, dst_op_load,
                     src_op_load, dst_ext_load, src_ext_load, ir_load, pc_load, pc_inc,
                     mem_wr, mem_rd};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic t_rst, input logic [15:0] t_ir, input logic t_rdy,
                       input logic t_jt, input logic [3:0] t_st, input logic [1:0] t_mab,
                       input logic [15:0] t_fl);
        vecs.push_back('{t_rst, t_ir, t_rdy, t_jt, t_st, t_mab, t_fl});
    endtask

    // driver + scoreboard: one call is one clock cycle
    task automatic step(input string tag, input logic t_rst, input logic [15:0] t_ir,
                        input logic t_rdy, input logic t_jt, input logic [3:0] t_st,
                        input logic [1:0] t_mab, input logic [15:0] t_fl);
        logic [21:0] exp_v;
        logic [21:0] got_v;
        rst = t_rst;
        ir  = t_ir;
        rdy = t_rdy;
        jt  = t_jt;
        exp_q.push_back({t_st, t_mab, t_fl});
        @(negedge clk);
        got_v = {state, mab_sel, got_fl};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got state=%0d mab_sel=%0d strobes=%h, expected state=%0d mab_sel=%0d strobes=%h",
                     tag, got_v[21:18], got_v[17:16], got_v[15:0],
                     exp_v[21:18], exp_v[17:16], exp_v[15:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        ir  = 16'h0000;
        rdy = 1'b0;
        jt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        add(1, 16'h0000, 1, 0, ST_FETCH,   MAB_PC,  16'h0000);
        // MOV R5,R6
        add(0, 16'h4506, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h4506, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h4506, 1, 0, ST_EXEC,    MAB_PC,  F_RWE | F_DONE);
        // ADD #0x1234,8(R7)
        add(0, 16'h50B7, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h50B7, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h50B7, 1, 0, ST_SRC_EXT, MAB_PC,  F_RD | F_SXL | F_PCI);
        add(0, 16'h50B7, 1, 0, ST_DST_EXT, MAB_PC,  F_RD | F_DXL | F_PCI);
        add(0, 16'h50B7, 1, 0, ST_DST_RD,  MAB_DST, F_RD | F_DOL);
        add(0, 16'h50B7, 1, 0, ST_EXEC,    MAB_PC,  F_SWE);
        add(0, 16'h50B7, 1, 0, ST_DST_WR,  MAB_DST, F_WR | F_DONE);
        // MOV.B @R9+,R4 and MOV.B @R1+,R4
        add(0, 16'h4974, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h4974, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h4974, 1, 0, ST_SRC_RD,  MAB_SRC, F_RD | F_SOL);
        add(0, 16'h4974, 1, 0, ST_EXEC,    MAB_PC,  F_RWE | F_AWE | F_AM1 | F_DONE);
        add(0, 16'h4174, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h4174, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h4174, 1, 0, ST_SRC_RD,  MAB_SRC, F_RD | F_SOL);
        add(0, 16'h4174, 1, 0, ST_EXEC,    MAB_PC,  F_RWE | F_AWE | F_AM2 | F_DONE);
        // JNE taken, then not taken
        add(0, 16'h2005, 1, 1, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h2005, 1, 1, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h2005, 1, 1, ST_JUMP,    MAB_PC,  F_PCL | F_DONE);
        add(0, 16'h2005, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h2005, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h2005, 1, 0, ST_JUMP,    MAB_PC,  F_DONE);
        // invalid format and CALL
        add(0, 16'h0000, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h0000, 1, 0, ST_DECODE,  MAB_PC,  F_ILL);
        add(0, 16'h1280, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h1280, 1, 0, ST_DECODE,  MAB_PC,  F_ILL);
        // ADD 2(R5),4(R6): indexed to indexed
        add(0, 16'h5596, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h5596, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h5596, 1, 0, ST_SRC_EXT, MAB_PC,  F_RD | F_SXL | F_PCI);
        add(0, 16'h5596, 1, 0, ST_SRC_RD,  MAB_SRC, F_RD | F_SOL);
        add(0, 16'h5596, 1, 0, ST_DST_EXT, MAB_PC,  F_RD | F_DXL | F_PCI);
        add(0, 16'h5596, 1, 0, ST_DST_RD,  MAB_DST, F_RD | F_DOL);
        add(0, 16'h5596, 1, 0, ST_EXEC,    MAB_PC,  F_SWE);
        add(0, 16'h5596, 1, 0, ST_DST_WR,  MAB_DST, F_WR | F_DONE);
        // CMP R5,8(R6): no writeback
        add(0, 16'h9586, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h9586, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h9586, 1, 0, ST_DST_EXT, MAB_PC,  F_RD | F_DXL | F_PCI);
        add(0, 16'h9586, 1, 0, ST_DST_RD,  MAB_DST, F_RD | F_DOL);
        add(0, 16'h9586, 1, 0, ST_EXEC,    MAB_PC,  F_SWE | F_DONE);
        // ADD #-1 (R3 constant),R4
        add(0, 16'h5334, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h5334, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h5334, 1, 0, ST_EXEC,    MAB_PC,  F_RWE | F_SWE | F_DONE);
        // MOV &abs,R4 (R2 with As=01 is not a constant)
        add(0, 16'h4214, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h4214, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h4214, 1, 0, ST_SRC_EXT, MAB_PC,  F_RD | F_SXL | F_PCI);
        add(0, 16'h4214, 1, 0, ST_SRC_RD,  MAB_SRC, F_RD | F_SOL);
        add(0, 16'h4214, 1, 0, ST_EXEC,    MAB_PC,  F_RWE | F_DONE);
        // RRA @R5: format II read-modify-write
        add(0, 16'h1125, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        add(0, 16'h1125, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        add(0, 16'h1125, 1, 0, ST_SRC_RD,  MAB_SRC, F_RD | F_SOL);
        add(0, 16'h1125, 1, 0, ST_EXEC,    MAB_PC,  F_SWE);
        add(0, 16'h1125, 1, 0, ST_DST_WR,  MAB_DST, F_WR | F_DONE);

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ir, vecs[i].rdy, vecs[i].jt,
                 vecs[i].st, vecs[i].mab, vecs[i].fl);

        // MOV.B @R9+,R4 with stalls in FETCH and SRC_RD; ready outside memory states is don't-care
        step("stall_fetch", 0, 16'h4974, 0, 1'($urandom_range(0, 1)), ST_FETCH, MAB_PC, F_RD);
        step("stall_fetch_go", 0, 16'h4974, 1, 1'($urandom_range(0, 1)), ST_FETCH, MAB_PC, F_FET);
        step("stall_decode", 0, 16'h4974, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ST_DECODE, MAB_PC, 16'h0000);
        n = $urandom_range(4, 6);
        for (int k = 0; k < n; k++)
            step($sformatf("stall_src_rd%0d", k), 0, 16'h4974, 0, 1'($urandom_range(0, 1)),
                 ST_SRC_RD, MAB_SRC, F_RD);
        step("stall_src_rd_go", 0, 16'h4974, 1, 0, ST_SRC_RD, MAB_SRC, F_RD | F_SOL);
        step("stall_exec", 0, 16'h4974, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ST_EXEC, MAB_PC, F_RWE | F_AWE | F_AM1 | F_DONE);

        // reset while a destination write is pending
        step("rst_f",   0, 16'h50B7, 1, 0, ST_FETCH,   MAB_PC,  F_FET);
        step("rst_d",   0, 16'h50B7, 1, 0, ST_DECODE,  MAB_PC,  16'h0000);
        step("rst_se",  0, 16'h50B7, 1, 0, ST_SRC_EXT, MAB_PC,  F_RD | F_SXL | F_PCI);
        step("rst_de",  0, 16'h50B7, 1, 0, ST_DST_EXT, MAB_PC,  F_RD | F_DXL | F_PCI);
        step("rst_dr",  0, 16'h50B7, 1, 0, ST_DST_RD,  MAB_DST, F_RD | F_DOL);
        step("rst_ex",  0, 16'h50B7, 1, 0, ST_EXEC,    MAB_PC,  F_SWE);
        step("rst_dw",  0, 16'h50B7, 0, 0, ST_DST_WR,  MAB_DST, F_WR);
        step("rst_hit", 1, 16'h50B7, 1, 0, ST_DST_WR,  MAB_PC,  16'h0000);
        step("rst_after_f", 0, 16'h4506, 1, 0, ST_FETCH,  MAB_PC, F_FET);
        step("rst_after_d", 0, 16'h4506, 1, 0, ST_DECODE, MAB_PC, 16'h0000);
        step("rst_after_x", 0, 16'h4506, 1, 0, ST_EXEC,   MAB_PC, F_RWE | F_DONE);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msp430_ctrl_fsm.md
Name: msp430_ctrl_fsm

Overview:
- Main control sequencer for the MSP430 core. It steps one instruction through fetch, extension-word fetch, operand reads, execute, memory writeback and jumps.
- It drives the MAB address-source select, the memory read/write strobes, PC increment/load, instruction-register load and the register-file/SR write enables.
- It reads the latched instruction word and the memory ready handshake, and sits between the instruction decoder, the PC/SP/SR muxes and the memory interface.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.
- CG_ENABLE, 1: when 1, constant-generator encodings (R3 any As; R2 with As=10/11) skip memory.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- ir  in  16  latched instruction word (valid from DECODE onward).
- mem_ready  in  1  memory accepted/returned the current access this cycle.
- jump_taken  in  1  condition evaluation for the jump in ir, valid in JUMP.
- mab_sel  out  2  0=PC, 1=source address, 2=destination address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- pc_inc  out  1  PC += 2 this cycle.
- pc_load  out  1  PC <= PC + 2*offset.
- ir_load  out  1  latch MDB into the instruction register.
- src_ext_load  out  1  latch MDB as the source extension word.
- dst_ext_load  out  1  latch MDB as the destination extension word.
- src_op_load  out  1  latch MDB as the source operand.
- dst_op_load  out  1  latch MDB as the destination operand.
- reg_we  out  1  register-file write of the ALU result.
- sr_we  out  1  SR flag update.
- ainc_we  out  1  autoincrement write to the operand register.
- ainc_amt  out  2  increment amount, 1 or 2.
- instr_done  out  1  one-cycle pulse at instruction retire.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

Behaviour:
- Reset: state=FETCH; every strobe/enable output is 0; mab_sel=0.
- rst wins over all other activity. An access in flight is abandoned with no write issued.
- Format: FMT_J when ir[15:13]=001; FMT_II when ir[15:12]=0001; FMT_I when ir[15:12]>=0100; anything else is illegal.
- Operand register R = ir[11:8] for FMT_I, ir[3:0] for FMT_II. As = ir[5:4]. Ad = ir[7], FMT_I only.
- need_src_ext: As=01, or As=11 with R=0. Constant-generator cases excluded.
- need_src_rd: As in {01,10}, or As=11 with R!=0. Constant-generator cases excluded.
- need_dst_ext: FMT_I and Ad=1.
- need_dst_rd: need_dst_ext and op != MOV (4'h4).
- need_dst_wr:
  - FMT_I: Ad=1 and op not in {CMP 4'h9, BIT 4'hB}.
  - FMT_II: need_src_rd and op in {RRC, SWPB, RRA, SXT}.
- FMT_II PUSH/CALL/RETI and invalid formats: illegal pulses in DECODE, next state FETCH, no writes.
- States and transitions:
  - FETCH: mab_sel=0, mem_rd=1. When mem_ready: ir_load=1, pc_inc=1, go to DECODE.
  - DECODE: next state is JUMP if FMT_J; else SRC_EXT, SRC_RD, DST_EXT, DST_RD or EXEC, first needed in that order.
  - SRC_EXT: mab_sel=0, mem_rd. When mem_ready: src_ext_load, pc_inc.
  - SRC_RD: mab_sel=1, mem_rd. When mem_ready: src_op_load.
  - DST_EXT: mab_sel=0, mem_rd. When mem_ready: dst_ext_load, pc_inc.
  - DST_RD: mab_sel=2, mem_rd. When mem_ready: dst_op_load.
  - EXEC (one cycle):
    - sr_we = MSR rule per opcode.
    - reg_we = rw && !need_dst_wr.
    - ainc_we when As=11 and R!=0; ainc_amt=1 if BW=1 and R not in {0,1}, else 2.
    - Next state DST_WR if need_dst_wr, else FETCH with instr_done.
  - DST_WR: mab_sel=2, mem_wr. When mem_ready: instr_done, go to FETCH.
  - JUMP (one cycle): pc_load=jump_taken, instr_done=1, go to FETCH.
- Memory states hold every output stable while mem_ready=0; there is no timeout.
- Latency with mem_ready always 1:
  - reg-reg: 3 cycles.
  - jump: 3 cycles.
  - immediate to indexed ADD: 7 cycles.
  - indexed to indexed ADD: 8 cycles.
- A mem_ready seen outside a memory state is ignored.

Decomposition:
- Shared header msp430_ops.vh gains:
  - state encodings ST_FETCH..ST_JUMP (4-bit);
  - MAB_PC/MAB_SRC/MAB_DST codes;
  - FMT_I/FMT_II/FMT_J;
  - the existing OP_*/FS_* constants.
- Sub-module msp430_mode_dec is purely combinational. Input ir. Outputs: fmt, need_src_ext, need_src_rd, need_dst_ext, need_dst_rd, need_dst_wr, ainc, ainc_amt, illegal_op, msr.

Test Plan:
- MOV R5,R6 (ir=16'h4506), mem_ready=1 → states FETCH, DECODE, EXEC; reg_we=1 in EXEC; instr_done on cycle 3; no mem_wr.
- ADD #0x1234,8(R7) (ir=16'h50B7) → FETCH, DECODE, SRC_EXT, DST_EXT, DST_RD, EXEC, DST_WR; pc_inc three times; mem_wr with mab_sel=2; sr_we=1; reg_we=0.
- MOV.B @R9+,R4 (ir=16'h4974) → SRC_RD then EXEC with ainc_we=1, ainc_amt=1; the same instruction on R1 (ir=16'h4174) gives ainc_amt=2.
- JNE with jump_taken=1, then with jump_taken=0 → pc_load follows jump_taken exactly; instr_done each time; total 3 cycles.
- Hold mem_ready=0 for 4 cycles during SRC_RD → outputs frozen; the sequence resumes identically afterwards. Assert rst in DST_WR → next cycle state=FETCH, mem_wr=0.
- ir=16'h0000 and ir=16'h1280 (CALL) → illegal pulses in DECODE; no writes; next state FETCH.
